// File: rtl/tm_key_debounce.sv
// Debounces the TM1638 raw key bitmap into clean levels and press/release strobes,
// and queues key-press codes in a small FIFO behind a valid/ready handshake.
module tm_key_debounce #(
  parameter int clk_mhz     = 27,
  parameter int w_key       = 8,
  parameter int debounce_ms = 10,
  parameter int fifo_depth  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [w_key-1:0]         key_raw,
  output logic [w_key-1:0]         key_state,
  output logic [w_key-1:0]         key_press,
  output logic [w_key-1:0]         key_release,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [$clog2(w_key)-1:0] ev_code,
  output logic                     ev_overflow
);

  localparam int TICK_CYCLES = clk_mhz * 1000;
  localparam int PW          = $clog2(TICK_CYCLES);
  localparam int CW          = $clog2(debounce_ms + 1);
  localparam int KW          = $clog2(w_key);
  localparam int AW          = $clog2(fifo_depth);

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(debounce_ms - 1);

  logic [PW-1:0]             presc_q, presc_d;
  logic                      tick_q, tick_d;
  logic [w_key-1:0]          raw_q, raw_d;
  logic [w_key-1:0][CW-1:0]  cnt_q, cnt_d;
  logic [w_key-1:0]          key_state_q, key_state_d;
  logic [w_key-1:0]          state_prev_q, state_prev_d;
  logic [w_key-1:0]          key_press_q, key_press_d;
  logic [w_key-1:0]          key_release_q, key_release_d;
  logic [w_key-1:0]          pend_q, pend_d;
  logic                      ovf_q, ovf_d;
  logic [AW:0]               wr_ptr_q, wr_ptr_d;
  logic [AW:0]               rd_ptr_q, rd_ptr_d;
  logic [KW-1:0]             mem [fifo_depth];

  logic                      fifo_empty;
  logic                      fifo_full;
  logic                      pop;
  logic                      push;
  logic                      sel_found;
  logic [KW-1:0]             sel_idx;
  logic [w_key-1:0]          clear_mask;

  always_comb begin
    presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
    tick_d  = (presc_q == PRESC_LAST);
    raw_d   = key_raw;
  end

  // Counters only move on the 1 ms tick, so a level must persist debounce_ms samples to flip.
  always_comb begin
    key_state_d = key_state_q;
    cnt_d       = cnt_q;
    if (tick_q) begin
      for (int i = 0; i < w_key; i++) begin
        if (raw_q[i] == key_state_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          key_state_d[i] = ~key_state_q[i];
          cnt_d[i]       = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    state_prev_d  = key_state_q;
    key_press_d   = key_state_q & ~state_prev_q;
    key_release_d = ~key_state_q & state_prev_q;
  end

  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop        = !fifo_empty && ev_ready;
  end

  // Lowest-index pending key wins; scanning downward lets the last hit be the lowest.
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = w_key - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        sel_idx   = KW'(i);
        sel_found = 1'b1;
      end
    end
  end

  // A new press on a bit that is already pending (even one being pushed now) is merged and flagged.
  always_comb begin
    push       = sel_found && (!fifo_full || pop);
    clear_mask = '0;
    if (push) begin
      clear_mask[sel_idx] = 1'b1;
    end
    pend_d   = (pend_q & ~clear_mask) | key_press_q;
    ovf_d    = ovf_q | (|(key_press_q & pend_q));
    wr_ptr_d = wr_ptr_q + (AW + 1)'(push);
    rd_ptr_d = rd_ptr_q + (AW + 1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q       <= '0;
      tick_q        <= 1'b0;
      raw_q         <= '0;
      cnt_q         <= '0;
      key_state_q   <= '0;
      state_prev_q  <= '0;
      key_press_q   <= '0;
      key_release_q <= '0;
      pend_q        <= '0;
      ovf_q         <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      presc_q       <= presc_d;
      tick_q        <= tick_d;
      raw_q         <= raw_d;
      cnt_q         <= cnt_d;
      key_state_q   <= key_state_d;
      state_prev_q  <= state_prev_d;
      key_press_q   <= key_press_d;
      key_release_q <= key_release_d;
      pend_q        <= pend_d;
      ovf_q         <= ovf_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q[AW-1:0]] <= sel_idx;
    end
  end

  // Storage is never cleared, so the head is masked to keep ev_code at 0 while empty.
  always_comb begin
    key_state   = key_state_q;
    key_press   = key_press_q;
    key_release = key_release_q;
    ev_valid    = !fifo_empty;
    ev_code     = fifo_empty ? '0 : mem[rd_ptr_q[AW-1:0]];
    ev_overflow = ovf_q;
  end

endmodule

// File: tb/tb_tm_key_debounce.sv
// Directed bench for tm_key_debounce: 1 MHz clock model, 3 ms debounce, 4-entry event FIFO.
module tb_tm_key_debounce;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] key_raw = 8'h00;
  logic       ev_ready = 1'b1;
  logic [7:0] key_state;
  logic [7:0] key_press;
  logic [7:0] key_release;
  logic       ev_valid;
  logic [2:0] ev_code;
  logic       ev_overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int press_cnt [8];
  int release_cnt [8];
  int ev_log [$];
  int ev_cyc [$];

  tm_key_debounce #(
    .clk_mhz    (1),
    .w_key      (8),
    .debounce_ms(3),
    .fifo_depth (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_raw    (key_raw),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_code    (ev_code),
    .ev_overflow(ev_overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe counts and accepted events are observed on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 8; i++) begin
        press_cnt[i]   = press_cnt[i] + int'(key_press[i]);
        release_cnt[i] = release_cnt[i] + int'(key_release[i]);
      end
      if (ev_valid && ev_ready) begin
        ev_log.push_back(int'(ev_code));
        ev_cyc.push_back(cyc);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] raw, input logic ready);
    key_raw  = raw;
    ev_ready = ready;
  endtask

  task automatic waitState(input string tag, input logic [7:0] want, input int budget);
    int n = 0;
    while (key_state !== want && n < budget) begin
      step(1);
      n++;
    end
    checkOutput(tag, 32'(key_state), 32'(want));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_state"}, 32'(key_state), 32'h0);
    checkOutput({tag, "_press"}, 32'(key_press), 32'h0);
    checkOutput({tag, "_release"}, 32'(key_release), 32'h0);
    checkOutput({tag, "_valid"}, 32'(ev_valid), 32'h0);
    checkOutput({tag, "_code"}, 32'(ev_code), 32'h0);
    checkOutput({tag, "_overflow"}, 32'(ev_overflow), 32'h0);
  endtask

  function automatic int logAt(input int idx);
    return (idx < ev_log.size()) ? ev_log[idx] : -1;
  endfunction

  initial begin
    int c0;
    int t0;
    int t1;
    int n;
    int n0;
    int tr;
    int total;

    applyStimulus(8'h00, 1'b1);
    rst_n = 1'b0;
    step(3);
    checkAllZero("reset");

    // Stable press of key 2
    rst_n = 1'b1;
    applyStimulus(8'h04, 1'b1);
    c0 = cyc;
    step(2500);
    checkOutput("stable_before_3rd_tick", 32'(key_state), 32'h0);
    waitState("stable_press_state", 8'h04, 1000);
    t0 = cyc;
    checkOutput("stable_flip_window", 32'((t0 - c0 >= 2999) && (t0 - c0 <= 3002)), 32'h1);
    n = 0;
    while (!ev_valid && n < 10) begin
      step(1);
      n++;
    end
    checkOutput("press_to_valid_latency", 32'(cyc - t0), 32'd3);
    checkOutput("stable_code", 32'(ev_code), 32'd2);
    step(1500);
    total = 0;
    for (int i = 0; i < 8; i++) total += press_cnt[i];
    checkOutput("stable_press_pulses_bit2", 32'(press_cnt[2]), 32'd1);
    checkOutput("stable_press_pulses_total", 32'(total), 32'd1);
    checkOutput("stable_event_count", 32'(ev_log.size()), 32'd1);
    checkOutput("stable_event_code", 32'(logAt(0)), 32'd2);
    applyStimulus(8'h00, 1'b1);
    waitState("stable_release_state", 8'h00, 4100);
    t1 = cyc;
    step(10);
    checkOutput("stable_release_pulses", 32'(release_cnt[2]), 32'd1);
    checkOutput("release_no_event", 32'(ev_log.size()), 32'd1);

    // Glitch on key 0 aligned just after a tick edge, so it spans only two ticks
    while ((cyc - t1) % 1000 != 0) step(1);
    applyStimulus(8'h01, 1'b1);
    step(2500);
    checkOutput("glitch_mid_state", 32'(key_state), 32'h0);
    applyStimulus(8'h00, 1'b1);
    step(2000);
    checkOutput("glitch_state", 32'(key_state), 32'h0);
    checkOutput("glitch_press_pulses", 32'(press_cnt[0]), 32'd0);
    checkOutput("glitch_no_event", 32'(ev_log.size()), 32'd1);

    // Simultaneous press of keys 0 and 7
    n0 = ev_log.size();
    applyStimulus(8'h81, 1'b1);
    waitState("simul_state", 8'h81, 4100);
    step(10);
    checkOutput("simul_event_count", 32'(ev_log.size()), 32'(n0 + 2));
    checkOutput("simul_first_code", 32'(logAt(n0)), 32'd0);
    checkOutput("simul_second_code", 32'(logAt(n0 + 1)), 32'd7);
    checkOutput("simul_consecutive",
                32'((ev_cyc.size() >= n0 + 2) ? (ev_cyc[n0 + 1] - ev_cyc[n0]) : -1), 32'd1);
    applyStimulus(8'h00, 1'b1);
    waitState("simul_release_state", 8'h00, 4100);

    // Backpressure: keys 1..5 in turn with the consumer stalled
    n0 = ev_log.size();
    applyStimulus(8'h02, 1'b0);
    waitState("bp_key1_state", 8'h02, 4100);
    for (int k = 2; k <= 5; k++) begin
      applyStimulus(8'(1 << k), 1'b0);
      waitState("bp_step_state", 8'(1 << k), 4100);
    end
    applyStimulus(8'h00, 1'b0);
    waitState("bp_release_state", 8'h00, 4100);
    step(10);
    checkOutput("bp_valid", 32'(ev_valid), 32'h1);
    checkOutput("bp_head_code", 32'(ev_code), 32'd1);
    checkOutput("bp_nothing_popped", 32'(ev_log.size()), 32'(n0));
    step(5);
    checkOutput("bp_head_stable", 32'(ev_code), 32'd1);
    applyStimulus(8'h00, 1'b1);
    step(8);
    checkOutput("bp_drain_count", 32'(ev_log.size()), 32'(n0 + 5));
    for (int j = 0; j < 5; j++) begin
      checkOutput("bp_drain_order", 32'(logAt(n0 + j)), 32'(j + 1));
    end
    checkOutput("bp_drained_valid", 32'(ev_valid), 32'h0);
    checkOutput("bp_overflow", 32'(ev_overflow), 32'h0);

    // Overflow: fill with keys 0..3, park key 6 as pending, then press key 6 again
    applyStimulus(8'h0F, 1'b0);
    waitState("ovf_fill_state", 8'h0F, 4100);
    step(10);
    checkOutput("ovf_fill_head", 32'(ev_code), 32'd0);
    applyStimulus(8'h4F, 1'b0);
    waitState("ovf_pend6_state", 8'h4F, 4100);
    step(10);
    checkOutput("ovf_not_yet", 32'(ev_overflow), 32'h0);
    applyStimulus(8'h0F, 1'b0);
    waitState("ovf_release6_state", 8'h0F, 4100);
    applyStimulus(8'h4F, 1'b0);
    waitState("ovf_repress6_state", 8'h4F, 4100);
    step(5);
    checkOutput("ovf_set", 32'(ev_overflow), 32'h1);
    step(1000);
    checkOutput("ovf_sticky", 32'(ev_overflow), 32'h1);

    // Mid-operation reset with two events queued and key 3 held
    n0 = ev_log.size();
    applyStimulus(8'h08, 1'b1);
    step(3);
    applyStimulus(8'h08, 1'b0);
    checkOutput("pre_reset_pops", 32'(ev_log.size()), 32'(n0 + 3));
    checkOutput("pre_reset_pop0", 32'(logAt(n0)), 32'd0);
    checkOutput("pre_reset_pop2", 32'(logAt(n0 + 2)), 32'd2);
    checkOutput("pre_reset_valid", 32'(ev_valid), 32'h1);
    checkOutput("pre_reset_head", 32'(ev_code), 32'd3);
    rst_n = 1'b0;
    step(1);
    checkAllZero("midreset");
    rst_n = 1'b1;
    applyStimulus(8'h08, 1'b1);
    tr = cyc;
    n0 = ev_log.size();
    n = 0;
    while (ev_log.size() <= n0 && n < 5000) begin
      step(1);
      n++;
    end
    step(5);
    checkOutput("after_reset_event_count", 32'(ev_log.size()), 32'(n0 + 1));
    checkOutput("after_reset_code", 32'(logAt(n0)), 32'd3);
    checkOutput("after_reset_delay_window",
                32'((ev_cyc.size() > n0) && (ev_cyc[n0] - tr >= 3000) && (ev_cyc[n0] - tr <= 4000)), 32'h1);
    checkOutput("after_reset_overflow", 32'(ev_overflow), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tm_key_debounce.md
# tm_key_debounce

Debounces and event-encodes the raw key bitmap returned by the TM1638 board controller. It sits between the controller's `keys` output and the driver's `key` input. It outputs a clean per-key level, one-cycle press/release strobes, and a buffered stream of key-press codes. The stream uses a valid/ready handshake, so a consumer never misses a press, even one shorter than its own processing time.

## Interface

- `clk_mhz`, 27: clock frequency in MHz; sets the 1 ms sample-tick prescaler (`clk_mhz*1000` cycles).
- `w_key`, 8: number of keys.
- `debounce_ms`, 10: consecutive differing 1 ms samples required to accept a level change; legal range 1..255.
- `fifo_depth`, 4: press-event FIFO depth; power of two, ≥ 2.

Ports:

- `clk` input 1: single clock.
- `rst_n` input 1: reset, synchronous and active-low; all state clears on the rising `clk` edge that samples `rst_n`=0.
- `key_raw` input `w_key`: raw key bitmap from the board controller; 1 = pressed.
- `key_state` output `w_key`: debounced level.
- `key_press` output `w_key`: one-cycle strobe on a debounced 0→1 transition.
- `key_release` output `w_key`: one-cycle strobe on a debounced 1→0 transition.
- `ev_valid` output 1: FIFO non-empty.
- `ev_ready` input 1: consumer accepts the head event when `ev_valid`&&`ev_ready`.
- `ev_code` output `$clog2(w_key)`: index of the pressed key at the FIFO head.
- `ev_overflow` output 1: sticky; set when a press is lost; cleared only by reset.

## Operation

- **Prescaler.**
  - Counter `0..clk_mhz*1000-1`.
  - `tick` is high for one cycle when the counter wraps.
  - Reset value 0; the first `tick` occurs `clk_mhz*1000` cycles after reset release.
- **Input register.** `key_raw` is registered once (`raw_q`) every cycle.
- **Per-key debounce.** Each key has a counter `cnt[i]` of width `$clog2(debounce_ms+1)`. On each `tick`:
  - If `raw_q[i]==key_state[i]`: `cnt[i]<=0`.
  - Else if `cnt[i]==debounce_ms-1`: `key_state[i]` flips, `cnt[i]<=0`.
  - Otherwise `cnt[i]` increments.
  - Between ticks the counters hold.
  - A glitch shorter than `debounce_ms` ticks never changes `key_state`.
- **Strobes.**
  - `key_press[i]`/`key_release[i]` are registered.
  - They are high exactly in the cycle after `key_state[i]` changes, for one cycle.
- **Pending mask.**
  - `pend[i]` is set by `key_press[i]`.
  - Each cycle, the lowest-index set bit of `pend` is pushed into the FIFO if the FIFO is not full, and that bit is cleared.
  - At most one push per cycle.
  - A press and a clear of the same bit in one cycle: the set wins (bit stays pending), and `ev_overflow` sets.
  - If `key_press[i]` arrives while `pend[i]` is already set and not being pushed, the press is merged and `ev_overflow` sets.
- **FIFO.**
  - Circular buffer of `fifo_depth` entries, with read/write pointers one bit wider than the address.
  - Full when the pointers differ only in the MSB.
  - Simultaneous push and pop is allowed when full.
  - Pop occurs on `ev_valid`&&`ev_ready`.
  - `ev_code` is the head entry, stable while `ev_valid`&&!`ev_ready`.
- **Reset values.**
  - All outputs are 0.
  - `key_state`, `pend`, `cnt`, FIFO pointers and prescaler clear to 0.
  - FIFO storage is not reset.
- **Reset mid-operation.**
  - Pending and queued events are discarded.
  - `key_state` returns to 0 even if keys are held; a held key re-debounces and produces a fresh press after reset.

## Timing

- Raw edge to `key_state`: `raw_q` is valid 1 cycle after `key_raw`; `key_state` flips on the `debounce_ms`-th subsequent tick.
  - Worst case: `debounce_ms*clk_mhz*1000 + clk_mhz*1000 + 1` cycles.
- `key_state` change → strobe: +1 cycle.
- Strobe → `pend`: +1 cycle.
- `pend` → FIFO write: +1 cycle.
- FIFO write → `ev_valid` high: same edge (registered count).
- Net from `key_state` flip to `ev_valid`: 3 cycles, with an empty FIFO and no lower-index pending bits.
- Back-to-back pops are sustainable at 1 event/cycle.

## Test plan

- Use `clk_mhz`=1, `debounce_ms`=3, `fifo_depth`=4, `w_key`=8 throughout.
- **Stable press:** `key_raw`=8'h04 held for 5000 cycles, `ev_ready`=1.
  - `key_state`=8'h04 after the 3rd tick.
  - One `key_press` pulse on bit 2.
  - Exactly one event with `ev_code`=2.
  - Releasing gives one `key_release` pulse and no event.
- **Glitch:** `key_raw`=8'h01 for 2500 cycles (≤2 ticks), then 0.
  - `key_state` stays 0; no strobes, no events.
- **Simultaneous press:** `key_raw`=8'h81 held, `ev_ready`=1.
  - Events `ev_code`=0 then 7 on consecutive cycles.
- **Backpressure / full:** `ev_ready`=0; keys 1, 2, 3, 4, 5 pressed and released sequentially.
  - 4 events are held in order 1, 2, 3, 4, and `pend[5]` stays set.
  - Raising `ev_ready` drains 1, 2, 3, 4, 5.
  - `ev_overflow`=0.
- **Overflow:** `ev_ready`=0 and FIFO full, with `pend[6]` set; key 6 pressed again.
  - `ev_overflow`=1 and stays 1 until reset.
- **Mid-operation reset:** `rst_n`=0 for 1 cycle while 2 events are queued and key 3 is held.
  - All outputs read 0 the next cycle.
  - After ~3–4 ms a new press event `ev_code`=3 appears.
